// File: rtl/threshold_bank_pkg.sv
// Shared types for the threshold bank: per-channel FSM state encoding and channel-index width helper.
// Latency: none (types and constant functions only).
// Backpressure: none.
package threshold_bank_pkg;

  // Per-channel hysteresis/debounce states (2-bit encoding)
  typedef enum logic [1:0] {
    BELOW     = 2'd0,
    PEND_RISE = 2'd1,
    ACTIVE    = 2'd2,
    PEND_FALL = 2'd3
  } chan_state_t;

  // Channel index width; a single-channel bank still carries a 1-bit index
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/threshold_bank_chan_fsm.sv
// One channel: hi/lo threshold registers plus hysteresis FSM with debounce counter.
// Latency: level flag and change pulse are registered on the edge that accepts the completing sample.
// Backpressure: none; every strobed sample is consumed in the cycle it arrives.
module threshold_bank_chan_fsm
  import threshold_bank_pkg::*;
#(
  parameter int                        DATA_W   = 16,
  parameter int                        DEBOUNCE = 3,
  parameter logic signed [DATA_W-1:0]  HI_RST   = 16'sd1000,
  parameter logic signed [DATA_W-1:0]  LO_RST   = 16'sd800,
  localparam int                       CNT_W    = $clog2(DEBOUNCE + 1)
) (
  input  logic                     update_clk,
  input  logic                     reset,
  input  logic                     smp_vld,
  input  logic signed [DATA_W-1:0] smp_x,
  input  logic                     cfg_vld,
  input  logic signed [DATA_W-1:0] cfg_hi,
  input  logic signed [DATA_W-1:0] cfg_lo,
  output logic                     level,
  output logic                     chg_vld
);

  chan_state_t              state;
  logic        [CNT_W-1:0]  cnt;
  logic signed [DATA_W-1:0] hi;
  logic signed [DATA_W-1:0] lo;
  logic                     cnt_done;

  // The sample that would bring the counter up to DEBOUNCE completes the switch
  assign cnt_done = (int'(cnt) + 1) == DEBOUNCE;

  // Threshold update and state advance; a same-cycle sample still sees the old hi/lo
  always_ff @(posedge update_clk) begin
    if (reset) begin
      state   <= BELOW;
      cnt     <= '0;
      level   <= 1'b0;
      chg_vld <= 1'b0;
      hi      <= HI_RST;
      lo      <= LO_RST;
    end else begin
      chg_vld <= 1'b0;
      if (cfg_vld) begin
        hi <= cfg_hi;
        lo <= cfg_lo;
      end
      if (smp_vld) begin
        case (state)
          BELOW: begin
            if (smp_x > hi) begin
              if (DEBOUNCE == 1) begin
                state   <= ACTIVE;
                level   <= 1'b1;
                chg_vld <= 1'b1;
              end else begin
                state <= PEND_RISE;
                cnt   <= CNT_W'(1);
              end
            end
          end
          PEND_RISE: begin
            if (smp_x > hi) begin
              if (cnt_done) begin
                state   <= ACTIVE;
                cnt     <= '0;
                level   <= 1'b1;
                chg_vld <= 1'b1;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end else begin
              state <= BELOW;
              cnt   <= '0;
            end
          end
          ACTIVE: begin
            if (smp_x < lo) begin
              if (DEBOUNCE == 1) begin
                state   <= BELOW;
                level   <= 1'b0;
                chg_vld <= 1'b1;
              end else begin
                state <= PEND_FALL;
                cnt   <= CNT_W'(1);
              end
            end
          end
          PEND_FALL: begin
            if (smp_x < lo) begin
              if (cnt_done) begin
                state   <= BELOW;
                cnt     <= '0;
                level   <= 1'b0;
                chg_vld <= 1'b1;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end else begin
              state <= ACTIVE;
              cnt   <= '0;
            end
          end
          default: begin
            state <= BELOW;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/threshold_bank.sv
// Multi-channel hysteresis + debounce on a channel-tagged sample stream; optional alarm latch bank (THRESHOLD_LATCH_EN).
// Latency: threshold/event 1 cycle after the completing sample; cfg_err 1 cycle after a rejected write.
// Backpressure: none; samples and config writes are accepted every cycle, invalid ones are dropped.
module threshold_bank
  import threshold_bank_pkg::*;
#(
  parameter int                        CHANNELS = 4,
  parameter int                        DATA_W   = 16,
  parameter int                        DEBOUNCE = 3,
  parameter logic signed [DATA_W-1:0]  HI_RST   = 16'sd1000,
  parameter logic signed [DATA_W-1:0]  LO_RST   = 16'sd800,
  localparam int                       CH_W     = ch_w(CHANNELS)
) (
  input  logic                     update_clk,
  input  logic                     reset,
  input  logic                     data_valid,
  input  logic [CH_W-1:0]          data_ch,
  input  logic signed [DATA_W-1:0] data_x,
  input  logic                     cfg_we,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic signed [DATA_W-1:0] cfg_hi,
  input  logic signed [DATA_W-1:0] cfg_lo,
  output logic                     cfg_err,
  output logic [CHANNELS-1:0]      threshold,
  output logic                     event_valid,
  output logic [CH_W-1:0]          event_ch,
  output logic                     event_rise
`ifdef THRESHOLD_LATCH_EN
  ,
  input  logic [CHANNELS-1:0]      alarm_clr,
  output logic [CHANNELS-1:0]      alarm_latched
`endif
);

  logic                data_ch_ok;
  logic                cfg_ok;
  logic [CHANNELS-1:0] smp_vld;
  logic [CHANNELS-1:0] cfg_vld;
  logic [CHANNELS-1:0] chg_vld;

  assign data_ch_ok = int'(data_ch) < CHANNELS;
  assign cfg_ok     = cfg_we && (int'(cfg_ch) < CHANNELS) && !(cfg_lo > cfg_hi);

  genvar g;
  generate
    for (g = 0; g < CHANNELS; g++) begin : g_chan
      assign smp_vld[g] = data_valid && data_ch_ok && (int'(data_ch) == g);
      assign cfg_vld[g] = cfg_ok && (int'(cfg_ch) == g);

      threshold_bank_chan_fsm #(
        .DATA_W   (DATA_W),
        .DEBOUNCE (DEBOUNCE),
        .HI_RST   (HI_RST),
        .LO_RST   (LO_RST)
      ) u_chan (
        .update_clk (update_clk),
        .reset      (reset),
        .smp_vld    (smp_vld[g]),
        .smp_x      (data_x),
        .cfg_vld    (cfg_vld[g]),
        .cfg_hi     (cfg_hi),
        .cfg_lo     (cfg_lo),
        .level      (threshold[g]),
        .chg_vld    (chg_vld[g])
      );
    end
  endgenerate

  // Rejected write: reversed thresholds or channel outside the bank
  always_ff @(posedge update_clk) begin
    if (reset) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
    end
  end

  // Encode the change pulse; only the sampled channel can change, lowest index wins regardless
  always_comb begin
    event_valid = 1'b0;
    event_ch    = '0;
    event_rise  = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (chg_vld[i]) begin
        event_valid = 1'b1;
        event_ch    = CH_W'(i);
        event_rise  = threshold[i];
      end
    end
  end

`ifdef THRESHOLD_LATCH_EN
  // Sticky alarm per channel: rise sets, clear drops, set beats a simultaneous clear
  always_ff @(posedge update_clk) begin
    if (reset) begin
      alarm_latched <= '0;
    end else begin
      alarm_latched <= (alarm_latched & ~alarm_clr) | (chg_vld & threshold);
    end
  end
`endif

endmodule

// File: tb/tb_threshold_bank.sv
// Directed bench for threshold_bank: hysteresis, debounce, config validation, reset, optional latch bank.
// Latency: inputs driven and outputs checked on the falling edge, between DUT capture edges.
// Backpressure: none.
module tb_threshold_bank;

  logic               update_clk = 1'b0;
  logic               reset;
  logic               data_valid;
  logic [1:0]         data_ch;
  logic signed [15:0] data_x;
  logic               cfg_we;
  logic [1:0]         cfg_ch;
  logic signed [15:0] cfg_hi;
  logic signed [15:0] cfg_lo;
  logic               cfg_err;
  logic [3:0]         threshold;
  logic               event_valid;
  logic [1:0]         event_ch;
  logic               event_rise;
`ifdef THRESHOLD_LATCH_EN
  logic [3:0]         alarm_clr;
  logic [3:0]         alarm_latched;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 update_clk = ~update_clk;

  threshold_bank dut (
    .update_clk    (update_clk),
    .reset         (reset),
    .data_valid    (data_valid),
    .data_ch       (data_ch),
    .data_x        (data_x),
    .cfg_we        (cfg_we),
    .cfg_ch        (cfg_ch),
    .cfg_hi        (cfg_hi),
    .cfg_lo        (cfg_lo),
    .cfg_err       (cfg_err),
    .threshold     (threshold),
    .event_valid   (event_valid),
    .event_ch      (event_ch),
    .event_rise    (event_rise)
`ifdef THRESHOLD_LATCH_EN
    ,
    .alarm_clr     (alarm_clr),
    .alarm_latched (alarm_latched)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One sample on ch, returns on the next falling edge with its outputs visible
  task automatic smp(input int ch, input int x);
    data_valid = 1'b1;
    data_ch    = 2'(ch);
    data_x     = 16'(x);
    @(negedge update_clk);
    data_valid = 1'b0;
  endtask

  task automatic idle();
    @(negedge update_clk);
  endtask

  task automatic check_event(input string tag, input logic vld, input int ch, input logic rise);
    check({tag, ".ev_vld"}, 32'(event_valid), 32'(vld));
    if (vld) begin
      check({tag, ".ev_ch"}, 32'(event_ch), 32'(ch));
      check({tag, ".ev_rise"}, 32'(event_rise), 32'(rise));
    end
  endtask

  initial begin
    reset      = 1'b1;
    data_valid = 1'b0;
    data_ch    = '0;
    data_x     = '0;
    cfg_we     = 1'b0;
    cfg_ch     = '0;
    cfg_hi     = '0;
    cfg_lo     = '0;
`ifdef THRESHOLD_LATCH_EN
    alarm_clr  = '0;
`endif
    @(negedge update_clk);
    @(negedge update_clk);
    check("rst.thr", 32'(threshold), 32'h0);
    check("rst.ev", 32'(event_valid), 32'h0);
    check("rst.err", 32'(cfg_err), 32'h0);
    reset = 1'b0;
    idle();

    // ch0 rises after three samples above 1000
    smp(0, 1001); smp(0, 1001);
    check("ch0.pre", 32'(threshold), 32'h0);
    check_event("ch0.pre", 1'b0, 0, 1'b0);
    smp(0, 1001);
    check("ch0.rise.thr", 32'(threshold), 32'h1);
    check_event("ch0.rise", 1'b1, 0, 1'b1);
    idle();
    check("ch0.pulse_end", 32'(event_valid), 32'h0);

    // ch1: interrupted run, then values below hi never rise
    smp(1, 1001); smp(1, 1001); smp(1, 500);
    check("ch1.interrupt", 32'(threshold), 32'h1);
    check_event("ch1.interrupt", 1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      smp(1, 700);
      check_event("ch1.low", 1'b0, 0, 1'b0);
    end
    check("ch1.low.thr", 32'(threshold), 32'h1);

    // ch2 up, hold in band, then fall
    smp(2, 1001); smp(2, 1001); smp(2, 1001);
    check("ch2.rise.thr", 32'(threshold), 32'h5);
    check_event("ch2.rise", 1'b1, 2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      smp(2, 900);
      check("ch2.band.thr", 32'(threshold), 32'h5);
      check_event("ch2.band", 1'b0, 0, 1'b0);
    end
    smp(2, 799); smp(2, 799);
    check("ch2.prefall", 32'(threshold), 32'h5);
    smp(2, 799);
    check("ch2.fall.thr", 32'(threshold), 32'h1);
    check_event("ch2.fall", 1'b1, 2, 1'b0);

    // Band edges are inclusive: x==hi never rises, x==lo never falls
    smp(3, 1000); smp(3, 1000); smp(3, 1000);
    check("ch3.eq_hi", 32'(threshold), 32'h1);
    smp(0, 800); smp(0, 800); smp(0, 800);
    check("ch0.eq_lo", 32'(threshold), 32'h1);

    // ch0 keeps its fall count across a sample on another channel
    smp(0, 799); smp(0, 799); smp(1, 1001);
    check("ch0.interleave.pre", 32'(threshold), 32'h1);
    smp(0, 799);
    check("ch0.interleave.fall", 32'(threshold), 32'h0);
    check_event("ch0.fall", 1'b1, 0, 1'b0);

    // Reversed thresholds are rejected
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_hi = 16'sd100; cfg_lo = 16'sd200;
    idle();
    cfg_we = 1'b0;
    check("cfg.bad.err", 32'(cfg_err), 32'h1);
    idle();
    check("cfg.bad.err_end", 32'(cfg_err), 32'h0);
    smp(3, 150); smp(3, 150); smp(3, 150);
    check("cfg.bad.unchanged", 32'(threshold), 32'h0);

    // Valid write with a same-cycle sample: 500 is judged against the old hi=1000
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_hi = 16'sd200; cfg_lo = 16'sd100;
    smp(3, 500);
    cfg_we = 1'b0;
    check("cfg.good.err", 32'(cfg_err), 32'h0);
    smp(3, 201); smp(3, 201);
    check("cfg.old_thr", 32'(threshold), 32'h0);
    smp(3, 201);
    check("cfg.new_thr.rise", 32'(threshold), 32'h8);
    check_event("ch3.rise", 1'b1, 3, 1'b1);

    // Negative samples compare signed against lo=100
    smp(3, -5); smp(3, -5);
    check("ch3.neg.pre", 32'(threshold), 32'h8);
    smp(3, -5);
    check("ch3.neg.fall", 32'(threshold), 32'h0);
    check_event("ch3.neg", 1'b1, 3, 1'b0);

    // Reset in the middle of a rise debounce
    smp(1, 500);
    smp(1, 1001); smp(1, 1001);
    reset = 1'b1;
    idle();
    check("mid_rst.thr", 32'(threshold), 32'h0);
    check("mid_rst.ev", 32'(event_valid), 32'h0);
    check("mid_rst.err", 32'(cfg_err), 32'h0);
    reset = 1'b0;
    smp(1, 1001); smp(1, 1001);
    check("mid_rst.restart", 32'(threshold), 32'h0);
    smp(1, 1001);
    check("mid_rst.rise", 32'(threshold), 32'h2);
    check_event("mid_rst.rise", 1'b1, 1, 1'b1);

    // Reset restores ch3 hi to 1000
    smp(3, 500); smp(3, 500); smp(3, 500);
    check("rst.hi_restored", 32'(threshold), 32'h2);

`ifdef THRESHOLD_LATCH_EN
    smp(0, 1001); smp(0, 1001); smp(0, 1001);
    idle();
    check("latch.set", 32'(alarm_latched), 32'h3);
    smp(0, 799); smp(0, 799); smp(0, 799);
    smp(0, 1001); smp(0, 1001); smp(0, 1001);
    alarm_clr = 4'b0001;
    idle();
    alarm_clr = 4'b0000;
    check("latch.set_wins", 32'(alarm_latched[0]), 32'h1);
    alarm_clr = 4'b0001;
    idle();
    alarm_clr = 4'b0000;
    check("latch.clear", 32'(alarm_latched), 32'h2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
